// File: rtl/vote_pkg.sv
// vote_pkg: state encoding and count-width helper shared by the vote collector.
package vote_pkg;
  typedef enum logic {COLLECT = 1'b0, RESULT = 1'b1} state_t;
  function automatic int cw(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/majority_n_bit.sv
// majority_n_bit: combinational N-bit majority voter, F=1 iff more than N/2 inputs are set.
module majority_n_bit #(
  parameter int N = 5
) (
  input  logic [N-1:0] A,
  output logic         F
);
  assign F = $countones(A) > N / 2;
endmodule

// File: rtl/majority_vote_collector.sv
// majority_vote_collector: packs N serial votes into a window and reports count and majority.
module majority_vote_collector
  import vote_pkg::*;
#(
  parameter int N = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             vote_valid,
  input  logic             vote_bit,
  output logic             vote_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_votes,
  output logic [cw(N)-1:0] res_count,
  output logic             res_majority
);
  localparam int CW = cw(N);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  if (N < 1) begin : g_bad_n
    $error("majority_vote_collector: N must be >= 1");
  end
  state_t          r_state, w_state_next;
  logic [IW-1:0]   r_idx;
  logic [N-1:0]    r_window, w_window_next, r_res_votes;
  logic [CW-1:0]   r_count, w_count_next, r_res_count;
  logic            r_res_majority, w_accept, w_last;
  assign vote_ready   = (r_state == COLLECT) && !clear;
  assign w_accept     = vote_valid && vote_ready;
  assign w_last       = r_idx == IW'(N - 1);
  assign w_count_next = r_count + CW'(vote_bit);
  assign res_valid    = r_state == RESULT;
  assign res_votes    = r_res_votes;
  assign res_count    = r_res_count;
  assign res_majority = r_res_majority;
  always_comb begin
    w_window_next        = r_window;
    w_window_next[r_idx] = vote_bit;
    w_state_next = (r_state == COLLECT) ? ((w_accept && w_last) ? RESULT : COLLECT)
                                        : (res_ready ? COLLECT : RESULT);
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= COLLECT;
    else     r_state <= w_state_next;
  end
  // Window and count are zeroed as the round closes, so the next round starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx          <= '0;
      r_window       <= '0;
      r_count        <= '0;
      r_res_votes    <= '0;
      r_res_count    <= '0;
      r_res_majority <= 1'b0;
    end else if (r_state == COLLECT && clear) begin
      r_idx    <= '0;
      r_window <= '0;
      r_count  <= '0;
    end else if (w_accept) begin
      r_idx    <= w_last ? '0 : r_idx + 1'b1;
      r_window <= w_last ? '0 : w_window_next;
      r_count  <= w_last ? '0 : w_count_next;
      if (w_last) begin
        r_res_votes    <= w_window_next;
        r_res_count    <= w_count_next;
        r_res_majority <= w_count_next > CW'(N / 2);
      end
    end
  end
`ifndef SYNTHESIS
  logic w_chk_majority;
  majority_n_bit #(.N(N)) u_chk (.A(r_res_votes), .F(w_chk_majority));
  a_majority_xcheck: assert property (@(posedge clk) disable iff (rst)
    res_valid |-> (w_chk_majority == r_res_majority))
    else $error("majority cross-check disagrees with registered result");
`endif
endmodule

// File: tb/tb_majority_vote_collector.sv
// tb_majority_vote_collector: directed and randomized checks against a queue-based vote model.
module tb_majority_vote_collector;
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, vote_valid = 1'b0, vote_bit = 1'b0, res_ready = 1'b0;
  logic vote_ready, res_valid, res_majority;
  logic [4:0] res_votes;
  logic [2:0] res_count;
  logic v4 = 1'b0, b4 = 1'b0, r4 = 1'b0;
  logic rdy4, val4, maj4;
  logic [3:0] votes4;
  logic [2:0] cnt4;
  int n_checks = 0, n_pass = 0;
  bit m_q[$];
  logic m_pend = 1'b0, m_maj = 1'b0;
  logic [4:0] m_votes = '0;
  logic [2:0] m_cnt = '0;
  int m_rounds = 0;
  always #5 clk = ~clk;
  majority_vote_collector #(.N(5)) d5 (
    .clk(clk), .rst(rst), .clear(clear), .vote_valid(vote_valid), .vote_bit(vote_bit),
    .vote_ready(vote_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_votes(res_votes), .res_count(res_count), .res_majority(res_majority)
  );
  majority_vote_collector #(.N(4)) d4 (
    .clk(clk), .rst(rst), .clear(1'b0), .vote_valid(v4), .vote_bit(b4),
    .vote_ready(rdy4), .res_valid(val4), .res_ready(r4),
    .res_votes(votes4), .res_count(cnt4), .res_majority(maj4)
  );
  // Drives one cycle on the N=5 instance and advances the reference model across the edge.
  task automatic cyc(input logic v, input logic b, input logic c, input logic r);
    logic acc, hs;
    int s;
    vote_valid = v; vote_bit = b; clear = c; res_ready = r;
    acc = v && !c && !m_pend;
    hs  = m_pend && r;
    @(posedge clk);
    if (rst) begin
      m_q.delete(); m_pend = 1'b0; m_votes = '0; m_cnt = '0; m_maj = 1'b0;
    end else begin
      if (c && !m_pend) m_q.delete();
      else if (acc) begin
        m_q.push_back(b);
        if (m_q.size() == 5) begin
          s = 0; m_votes = '0;
          foreach (m_q[i]) begin
            s += int'(m_q[i]);
            if (m_q[i]) m_votes = m_votes | (5'd1 << i);
          end
          m_cnt = 3'(s); m_maj = (2 * s > 5); m_pend = 1'b1; m_q.delete();
        end
      end
      if (hs) begin m_pend = 1'b0; m_rounds++; end
    end
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    rst = 1'b0;
    n_checks++; if (res_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", res_valid); else n_pass++;
    n_checks++; if (res_votes !== 5'b0) $display("FAIL reset_votes: got %b want 00000", res_votes); else n_pass++;
    n_checks++; if (res_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", res_count); else n_pass++;
    n_checks++; if (res_majority !== 1'b0) $display("FAIL reset_majority: got %b want 0", res_majority); else n_pass++;
    n_checks++; if (vote_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", vote_ready); else n_pass++;
  endtask
  task automatic test_basic();
    logic [4:0] seq = 5'b01101;
    for (int i = 0; i < 5; i++) cyc(1, seq[i], 0, 1);
    n_checks++; if (res_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", res_valid); else n_pass++;
    n_checks++; if (res_votes !== 5'b01101) $display("FAIL basic_votes: got %b want 01101", res_votes); else n_pass++;
    n_checks++; if (res_count !== 3'd3) $display("FAIL basic_count: got %0d want 3", res_count); else n_pass++;
    n_checks++; if (res_majority !== 1'b1) $display("FAIL basic_majority: got %b want 1", res_majority); else n_pass++;
    n_checks++; if (vote_ready !== 1'b0) $display("FAIL basic_ready_in_result: got %b want 0", vote_ready); else n_pass++;
    cyc(0, 0, 0, 1);
    n_checks++; if (res_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", res_valid); else n_pass++;
    n_checks++; if (vote_ready !== 1'b1) $display("FAIL basic_ready_after: got %b want 1", vote_ready); else n_pass++;
  endtask
  task automatic test_hold();
    logic [4:0] seq = 5'b01001;
    for (int i = 0; i < 5; i++) cyc(1, seq[i], 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 0, 0);
      n_checks++; if (res_valid !== 1'b1) $display("FAIL hold_valid[%0d]: got %b want 1", k, res_valid); else n_pass++;
      n_checks++; if (res_votes !== 5'b01001) $display("FAIL hold_votes[%0d]: got %b want 01001", k, res_votes); else n_pass++;
      n_checks++; if (res_count !== 3'd2) $display("FAIL hold_count[%0d]: got %0d want 2", k, res_count); else n_pass++;
      n_checks++; if (res_majority !== 1'b0) $display("FAIL hold_majority[%0d]: got %b want 0", k, res_majority); else n_pass++;
      n_checks++; if (vote_ready !== 1'b0) $display("FAIL hold_ready[%0d]: got %b want 0", k, vote_ready); else n_pass++;
    end
    cyc(0, 0, 0, 1);
    n_checks++; if (res_valid !== 1'b0) $display("FAIL hold_release: got %b want 0", res_valid); else n_pass++;
  endtask
  task automatic test_clear();
    logic [4:0] seq = 5'b10000;
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    n_checks++; if (vote_ready !== 1'b0) $display("FAIL clear_ready: got %b want 0", vote_ready); else n_pass++;
    n_checks++; if (res_valid !== 1'b0) $display("FAIL clear_no_result: got %b want 0", res_valid); else n_pass++;
    for (int i = 0; i < 5; i++) cyc(1, seq[i], 0, 0);
    n_checks++; if (res_valid !== 1'b1) $display("FAIL clear_valid: got %b want 1", res_valid); else n_pass++;
    n_checks++; if (res_votes !== 5'b10000) $display("FAIL clear_votes: got %b want 10000", res_votes); else n_pass++;
    n_checks++; if (res_count !== 3'd1) $display("FAIL clear_count: got %0d want 1", res_count); else n_pass++;
    n_checks++; if (res_majority !== 1'b0) $display("FAIL clear_majority: got %b want 0", res_majority); else n_pass++;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
  endtask
  task automatic test_tie();
    logic [3:0] pat[2] = '{4'b0011, 4'b0111};
    logic [2:0] exp_cnt[2] = '{3'd2, 3'd3};
    logic exp_maj[2] = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin v4 = 1'b1; b4 = pat[k][i]; r4 = 1'b0; @(posedge clk); #1; end
      v4 = 1'b0;
      n_checks++; if (val4 !== 1'b1) $display("FAIL n4_valid[%0d]: got %b want 1", k, val4); else n_pass++;
      n_checks++; if (votes4 !== pat[k]) $display("FAIL n4_votes[%0d]: got %b want %b", k, votes4, pat[k]); else n_pass++;
      n_checks++; if (cnt4 !== exp_cnt[k]) $display("FAIL n4_count[%0d]: got %0d want %0d", k, cnt4, exp_cnt[k]); else n_pass++;
      n_checks++; if (maj4 !== exp_maj[k]) $display("FAIL n4_majority[%0d]: got %b want %b", k, maj4, exp_maj[k]); else n_pass++;
      r4 = 1'b1; @(posedge clk); #1; r4 = 1'b0;
      n_checks++; if (val4 !== 1'b0) $display("FAIL n4_release[%0d]: got %b want 0", k, val4); else n_pass++;
    end
  endtask
  task automatic test_rst_mid();
    logic [4:0] seq = 5'b11011;
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0);
    rst = 1'b1; cyc(0, 0, 0, 0); rst = 1'b0;
    n_checks++; if (vote_ready !== 1'b1 || res_valid !== 1'b0) $display("FAIL rstmid_round: ready %b valid %b want 1 0", vote_ready, res_valid); else n_pass++;
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0);
    n_checks++; if (res_valid !== 1'b1 || res_count !== 3'd5) $display("FAIL rstmid_full: valid %b count %0d want 1 5", res_valid, res_count); else n_pass++;
    rst = 1'b1; cyc(0, 0, 0, 0); rst = 1'b0;
    n_checks++; if (res_valid !== 1'b0) $display("FAIL rstres_valid: got %b want 0", res_valid); else n_pass++;
    n_checks++; if (res_votes !== 5'b0 || res_count !== 3'd0 || res_majority !== 1'b0) $display("FAIL rstres_fields: got %b %0d %b want 00000 0 0", res_votes, res_count, res_majority); else n_pass++;
    for (int i = 0; i < 5; i++) cyc(1, seq[i], 0, 0);
    n_checks++; if (res_votes !== 5'b11011 || res_count !== 3'd4 || res_majority !== 1'b1) $display("FAIL rstfresh: got %b %0d %b want 11011 4 1", res_votes, res_count, res_majority); else n_pass++;
    cyc(0, 0, 0, 1);
  endtask
  task automatic test_random();
    int n_cyc = 0;
    int start = m_rounds;
    while (m_rounds - start < 1000 && n_cyc < 40000) begin
      cyc(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 1'($urandom_range(19) == 0), 1'($urandom_range(1)));
      n_cyc++;
      n_checks++; if (res_valid !== m_pend) $display("FAIL rnd_valid@%0d: got %b want %b", n_cyc, res_valid, m_pend); else n_pass++;
      n_checks++; if (vote_ready !== (!m_pend && !clear)) $display("FAIL rnd_ready@%0d: got %b want %b", n_cyc, vote_ready, !m_pend && !clear); else n_pass++;
      n_checks++; if (res_votes !== m_votes) $display("FAIL rnd_votes@%0d: got %b want %b", n_cyc, res_votes, m_votes); else n_pass++;
      n_checks++; if (res_count !== m_cnt) $display("FAIL rnd_count@%0d: got %0d want %0d", n_cyc, res_count, m_cnt); else n_pass++;
      n_checks++; if (res_majority !== m_maj) $display("FAIL rnd_majority@%0d: got %b want %b", n_cyc, res_majority, m_maj); else n_pass++;
    end
    n_checks++; if (m_rounds - start < 1000) $display("FAIL rnd_rounds: got %0d want 1000", m_rounds - start); else n_pass++;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_clear();
    test_tie();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
